// File: rtl/register_file_pkg.sv
// Shared sizing defaults and address-width helper for the register file.
// No logic; constants and a constant function only.
// Imported by register_file and regfile_read_port.
package register_file_pkg;

    localparam int DEF_WIDTH = 5;
    localparam int DEF_DEPTH = 8;

    // Smallest width able to index every register; DEPTH=2 still needs one bit.
    function automatic int calc_addr_w(input int depth);
        int w;
        w = 1;
        while ((1 << w) < depth) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: address range check, storage mux, optional write-through (REGFILE_BYPASS_EN).
// Latency: data for the address sampled at edge N is visible after edge N.
// Backpressure: none; a new read is accepted every cycle.
module regfile_read_port
    import register_file_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = calc_addr_w(DEF_DEPTH)
) (
    input  logic                         core_clk,
    input  logic                         clear,
    input  logic [DEPTH-1:0][WIDTH-1:0]  regs,
    input  logic [ADDR_W-1:0]            addr,
`ifdef REGFILE_BYPASS_EN
    input  logic                         wr_vld,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [WIDTH-1:0]             wr_dat,
`endif
    output logic [WIDTH-1:0]             dat
);

    logic addr_ok;

    // A full power-of-two address space can never be out of range.
    generate
        if (DEPTH == (1 << ADDR_W)) begin : g_full
            assign addr_ok = 1'b1;
        end else begin : g_part
            assign addr_ok = (addr < ADDR_W'(DEPTH));
        end
    endgenerate

    always_ff @(posedge core_clk) begin
        if (clear) begin
            dat <= '0;
        end else if (!addr_ok) begin
            dat <= '0;
`ifdef REGFILE_BYPASS_EN
        end else if (wr_vld && (wr_addr == addr)) begin
            dat <= wr_dat;
`endif
        end else begin
            dat <= regs[addr];
        end
    end

endmodule

// File: rtl/register_file.sv
// DEPTH x WIDTH register file, one write port, two registered read ports; REGFILE_BYPASS_EN selects write-through.
// Latency: writes land on the edge; reads return one edge after the address is sampled.
// Backpressure: none; Clear overrides Load and zeroes storage and both outputs.
module register_file
    import register_file_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int ADDR_W = calc_addr_w(DEPTH)
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic              Load,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [WIDTH-1:0]  inData,
    input  logic [ADDR_W-1:0] rdAddrA,
    input  logic [ADDR_W-1:0] rdAddrB,
    output logic [WIDTH-1:0]  outDataA,
    output logic [WIDTH-1:0]  outDataB
);

    logic [DEPTH-1:0][WIDTH-1:0] regs;
    logic                        wr_ok;
    logic                        wr_vld;

    generate
        if (DEPTH == (1 << ADDR_W)) begin : g_full
            assign wr_ok = 1'b1;
        end else begin : g_part
            assign wr_ok = (wrAddr < ADDR_W'(DEPTH));
        end
    endgenerate

    assign wr_vld = Load && wr_ok;

    always_ff @(posedge Clock) begin
        if (Clear) begin
            regs <= '0;
        end else if (wr_vld) begin
            regs[wrAddr] <= inData;
        end
    end

    regfile_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_port_a (
        .core_clk (Clock),
        .clear    (Clear),
        .regs     (regs),
        .addr     (rdAddrA),
`ifdef REGFILE_BYPASS_EN
        .wr_vld   (wr_vld),
        .wr_addr  (wrAddr),
        .wr_dat   (inData),
`endif
        .dat      (outDataA)
    );

    regfile_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_port_b (
        .core_clk (Clock),
        .clear    (Clear),
        .regs     (regs),
        .addr     (rdAddrB),
`ifdef REGFILE_BYPASS_EN
        .wr_vld   (wr_vld),
        .wr_addr  (wrAddr),
        .wr_dat   (inData),
`endif
        .dat      (outDataB)
    );

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter: WIDTH, default 5, data width of each register in bits (range 1..32).
REQ-002 Parameter: DEPTH, default 8, number of registers (range 2..32; need not be a power of two).
REQ-003 Derived constant: ADDR_W = ceil(log2(DEPTH)), address width; not user-overridable.
REQ-004 Port: Clock, input, 1, single clock; all state updates on rising edge.
REQ-005 Port: Clear, input, 1, synchronous active-high reset; clears all registers and outputs.
REQ-006 Port: Load, input, 1, write enable for the write port.
REQ-007 Port: wrAddr, input, ADDR_W, write address.
REQ-008 Port: inData, input, WIDTH, write data.
REQ-009 Port: rdAddrA, input, ADDR_W, read port A address.
REQ-010 Port: rdAddrB, input, ADDR_W, read port B address.
REQ-011 Port: outDataA, output, WIDTH, registered read data for port A.
REQ-012 Port: outDataB, output, WIDTH, registered read data for port B.

Function
REQ-013 The module SHALL hold DEPTH independent WIDTH-bit registers; one write port, two read ports.
REQ-014 The module SHALL write inData into register[wrAddr] on a rising edge with Load=1, Clear=0, wrAddr<DEPTH.
REQ-015 The module SHALL leave every register unchanged on a rising edge with Load=0.
REQ-016 The module SHALL ignore writes with wrAddr>=DEPTH; no register changes.
REQ-017 The module SHALL register read data: outDataA/outDataB show register[rdAddrA/B] as sampled at edge N, visible after edge N (1-cycle latency).
REQ-018 The module SHALL drive 0 on a read port whose address is >=DEPTH.
REQ-019 The module SHALL let both read ports address the same register simultaneously; both return identical data.
REQ-020 The module SHALL resolve a write and a read to the same address on the same edge per REQ-025/REQ-026.
REQ-021 The module SHALL hold outDataA/outDataB stable between edges; outputs change only on rising edges.

Reset
REQ-022 The module SHALL, on a rising edge with Clear=1, set all DEPTH registers, outDataA and outDataB to 0.
REQ-023 The module SHALL give Clear priority over Load; Clear=1 with Load=1 discards the write, and all registers read 0.
REQ-024 The module SHALL have no reset-time dependence on in-flight reads; the first read after Clear deasserts returns 0 for every address.

Configuration
REQ-025 With macro REGFILE_BYPASS_EN defined, a same-edge write and read to the same valid address SHALL return the new inData on that read port (write-through).
REQ-026 Without REGFILE_BYPASS_EN, a same-edge write and read to the same address SHALL return the pre-write register value; the new value is visible on the next read.

Structure
REQ-027 A shared package SHALL hold the default WIDTH/DEPTH constants and the ADDR_W calculation function.
REQ-028 One sub-module, regfile_read_port, SHALL implement a single registered read port (mux, range check, bypass); it SHALL be instantiated twice.
REQ-029 Registers SHALL use reset-free storage apart from the synchronous Clear; no latches and no asynchronous logic.

Verification
REQ-030 Reset: write 5'd10 to addr 3, then Clear=1 for one edge -> next reads of addr 3 on A and B both return 0.
REQ-031 Write/read: Load=1, wrAddr=2, inData=5'd7; next edge rdAddrA=2 -> outDataA=7 one edge later; with Load=0 and inData=5'd5, data stays 7.
REQ-032 Priority: Load=1, Clear=1, wrAddr=1, inData=5'd9 -> register 1 reads 0.
REQ-033 Collision: register 4 holds 3; same edge Load=1, wrAddr=4, inData=5'd12, rdAddrA=4 -> outDataA=12 with REGFILE_BYPASS_EN, 3 without.
REQ-034 Range: DEPTH=6; write 5'd15 to addr 7 -> no register changes; read addr 7 -> 0; read addr 5 -> unchanged value.
REQ-035 Dual port: registers 0 and 6 hold 1 and 31; rdAddrA=0, rdAddrB=6 -> outDataA=1 and outDataB=31 on the same cycle.
